// File: rtl/imu_pkg.sv
// Shared definitions for the IMU sample filter.
// Holds the FSM state type, word/axis geometry, axis index constants and the
// byte-slice helpers that map between the 96-bit reader word and 16-bit axes.
// Byte i of a word sits at w[95-8i -: 8]; axis k is {byte 2k+1, byte 2k}.
package imu_pkg;

  localparam int NUM_AXES = 6;
  localparam int AXIS_W   = 16;
  localparam int SAMPLE_W = 96;

  localparam logic [2:0] AX_GX = 3'd0;
  localparam logic [2:0] AX_GY = 3'd1;
  localparam logic [2:0] AX_GZ = 3'd2;
  localparam logic [2:0] AX_AX = 3'd3;
  localparam logic [2:0] AX_AY = 3'd4;
  localparam logic [2:0] AX_AZ = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    PUBLISH
  } state_e;

  // Extract axis k. The byte pair arrives low byte first, so swap it.
  function automatic logic [AXIS_W-1:0] get_axis(input logic [SAMPLE_W-1:0] w,
                                                 input logic [2:0]          k);
    logic [AXIS_W-1:0] pair;
    pair = AXIS_W'(w >> (SAMPLE_W - AXIS_W - AXIS_W * int'(k)));
    return {pair[7:0], pair[15:8]};
  endfunction

  // Return w with axis k replaced by v, using the same little-endian pairing.
  function automatic logic [SAMPLE_W-1:0] put_axis(input logic [SAMPLE_W-1:0] w,
                                                   input logic [2:0]          k,
                                                   input logic [AXIS_W-1:0]   v);
    logic [SAMPLE_W-1:0] ins;
    logic [SAMPLE_W-1:0] mask;
    ins  = SAMPLE_W'({v[7:0], v[15:8]}) << (SAMPLE_W - AXIS_W - AXIS_W * int'(k));
    mask = SAMPLE_W'(16'hFFFF)          << (SAMPLE_W - AXIS_W - AXIS_W * int'(k));
    return (w & ~mask) | ins;
  endfunction

endpackage

// File: rtl/imu_sample_filter_ema_step.sv
// ema_step: combinational single-axis EMA update, shared by all six axes.
//   x       : new raw axis sample (signed Q16.0)
//   acc     : current accumulator (signed Q16.SHIFT)
//   seeded  : 0 -> load x directly, 1 -> acc + ((x<<<SHIFT) - acc) >>> SHIFT
//   acc_new : next accumulator value
module ema_step
  import imu_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic signed [AXIS_W-1:0]       x,
  input  logic signed [AXIS_W+SHIFT-1:0] acc,
  input  logic                           seeded,
  output logic signed [AXIS_W+SHIFT-1:0] acc_new
);

  localparam int ACC_W = AXIS_W + SHIFT;

  logic signed [ACC_W-1:0] x_sh;
  logic signed [ACC_W:0]   diff;
  logic signed [ACC_W-1:0] step;

  assign x_sh = {x, {SHIFT{1'b0}}};

  // One extra bit keeps the full-scale swing (e.g. +max to -min) exact.
  assign diff = {x_sh[ACC_W-1], x_sh} - {acc[ACC_W-1], acc};

  // The shifted step never exceeds the distance between acc and x_sh, so the
  // narrowed step and the sum both stay inside ACC_W bits.
  assign step = ACC_W'(diff >>> SHIFT);

  assign acc_new = seeded ? (acc + step) : x_sh;

endmodule

// File: rtl/imu_sample_filter.sv
// imu_sample_filter: detects new 96-bit IMU sample words, runs a per-axis
// exponential moving average (alpha = 2^-SHIFT) through one shared ema_step,
// and publishes the filtered word in the reader's byte layout.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   curr_data  : raw sample word from the IMU reader
//   filt_data  : filtered sample word (same packing as curr_data)
//   filt_valid : one-cycle pulse when filt_data updates
//   busy       : high while a sample is being processed
module imu_sample_filter
  import imu_pkg::*;
#(
  parameter int SHIFT = 2,
  parameter int NAXES = NUM_AXES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] curr_data,
  output logic [SAMPLE_W-1:0] filt_data,
  output logic                filt_valid,
  output logic                busy
);

  localparam int ACC_W = AXIS_W + SHIFT;

  state_e                  state_q,      state_d;
  logic [SAMPLE_W-1:0]     last_word_q,  last_word_d;
  logic [SAMPLE_W-1:0]     sample_q,     sample_d;
  logic [SAMPLE_W-1:0]     filt_data_q,  filt_data_d;
  logic [2:0]              idx_q,        idx_d;
  logic                    seeded_q,     seeded_d;
  logic                    filt_valid_q, filt_valid_d;
  logic signed [ACC_W-1:0] acc_q [NAXES];
  logic signed [ACC_W-1:0] acc_d [NAXES];

  logic [AXIS_W-1:0]       x_sel;
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [ACC_W-1:0] acc_new;

  // Shared datapath: the axis index steers both operands into one ema_step.
  assign x_sel   = get_axis(sample_q, idx_q);
  assign acc_sel = acc_q[idx_q];

  ema_step #(.SHIFT(SHIFT)) u_ema_step (
    .x       (x_sel),
    .acc     (acc_sel),
    .seeded  (seeded_q),
    .acc_new (acc_new)
  );

  always_comb begin
    // NOTE: every _d starts from its held value so no branch can infer a latch.
    state_d      = state_q;
    last_word_d  = last_word_q;
    sample_d     = sample_q;
    filt_data_d  = filt_data_q;
    idx_d        = idx_q;
    seeded_d     = seeded_q;
    filt_valid_d = 1'b0;
    acc_d        = acc_q;

    case (state_q)
      IDLE: begin
        // A repeated word is treated as no sample; a converged EMA is unchanged.
        if (curr_data != last_word_q) begin
          sample_d    = curr_data;
          last_word_d = curr_data;
          idx_d       = 3'd0;
          state_d     = UPDATE;
        end
      end
      UPDATE: begin
        acc_d[idx_q] = acc_new;
        if (idx_q == 3'(NAXES - 1)) begin
          state_d = PUBLISH;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      PUBLISH: begin
        // Dropping the fraction bits is the arithmetic shift (floor).
        for (int k = 0; k < NAXES; k++) begin
          filt_data_d = put_axis(filt_data_d, 3'(k), acc_q[k][ACC_W-1:SHIFT]);
        end
        filt_valid_d = 1'b1;
        seeded_d     = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_word_q  <= '0;
      sample_q     <= '0;
      filt_data_q  <= '0;
      idx_q        <= 3'd0;
      seeded_q     <= 1'b0;
      filt_valid_q <= 1'b0;
      // NOTE: the accumulators are filter state, not a buffer, so they are reset.
      for (int k = 0; k < NAXES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values.
      state_q      <= state_d;
      last_word_q  <= last_word_d;
      sample_q     <= sample_d;
      filt_data_q  <= filt_data_d;
      idx_q        <= idx_d;
      seeded_q     <= seeded_d;
      filt_valid_q <= filt_valid_d;
      acc_q        <= acc_d;
    end
  end

  assign filt_data  = filt_data_q;
  assign filt_valid = filt_valid_q;
  assign busy       = (state_q != IDLE);

endmodule
